// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a pixel-tick divider, line/frame strobes
// and a scaled sub-window coordinate; every output is decoded from the next position and registered.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   CLK_DIV   = 2,
  parameter int   CW        = 11,
  parameter int   WIN_X0    = 64,
  parameter int   WIN_Y0    = 0,
  parameter int   WIN_SHIFT = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic          pix_tick,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
  output logic          win_active,
  output logic [8:0]    WinX,
  output logic [7:0]    WinY
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [31:0]   HA       = 32'(H_ACTIVE);
  localparam logic [31:0]   VA       = 32'(V_ACTIVE);
  localparam logic [31:0]   HS_BEG   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0]   VS_BEG   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0]   HS_LEN   = 32'(H_SYNC);
  localparam logic [31:0]   VS_LEN   = 32'(V_SYNC);
  localparam logic [31:0]   WX0      = 32'(WIN_X0);
  localparam logic [31:0]   WY0      = 32'(WIN_Y0);
  localparam logic [31:0]   WW       = 32'(256 << WIN_SHIFT);
  localparam logic [31:0]   WH       = 32'(240 << WIN_SHIFT);

  logic [DW-1:0] div;
  logic [CW-1:0] nx, ny;
  logic [31:0]   ex, ey, xoff, yoff;
  logic          vis, win, hs_in, vs_in;

  // Next position; Reset forces (0,0) so the reset cycle decodes like any other.
  always_comb begin
    nx = DrawX;
    ny = DrawY;
    if (pix_tick) begin
      if (DrawX == H_LAST) begin
        nx = '0;
        ny = (DrawY == V_LAST) ? '0 : DrawY + CW'(1);
      end else begin
        nx = DrawX + CW'(1);
      end
    end
    if (Reset) begin
      nx = '0;
      ny = '0;
    end
  end

  // Offsets wrap when below the region start, so a single unsigned compare covers both bounds.
  assign ex    = 32'(nx);
  assign ey    = 32'(ny);
  assign xoff  = ex - WX0;
  assign yoff  = ey - WY0;
  assign hs_in = (ex - HS_BEG) < HS_LEN;
  assign vs_in = (ey - VS_BEG) < VS_LEN;
  assign vis   = (ex < HA) && (ey < VA);
  assign win   = vis && (xoff < WW) && (yoff < WH);
  assign sync  = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div      <= '0;
      pix_tick <= 1'b0;
    end else begin
      div      <= (div == DIV_LAST) ? '0 : div + DW'(1);
      pix_tick <= (div == DIV_LAST);
    end
    DrawX       <= nx;
    DrawY       <= ny;
    hs          <= hs_in ? HS_POL : ~HS_POL;
    vs          <= vs_in ? VS_POL : ~VS_POL;
    blank       <= vis;
    line_start  <= !Reset && pix_tick && (nx == '0);
    frame_start <= !Reset && pix_tick && (nx == '0) && (ny == '0);
    win_active  <= win;
    WinX        <= win ? 9'(xoff >> WIN_SHIFT) : '0;
    WinY        <= win ? 8'(yoff >> WIN_SHIFT) : '0;
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Four differently configured generators run side by side with random resets; each is checked
// every cycle against a position computed from the cycle count since reset, plus literal boundary pins.
module tb_vga_timing_gen;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, div, wx, wy, ws;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst [4];
  logic       pt [4], hs [4], vs [4], bl [4], sy [4], ls [4], fs [4], wa [4];
  logic [10:0] dx [4], dy [4];
  logic [8:0] wx [4];
  logic [7:0] wy [4];
  int         k [4] = '{-1, -1, -1, -1};
  cfg_t       cfg [4];
  int         checks = 0, errors = 0;
  logic [15:0] hit = '0;

  always #10 clk = ~clk;

  vga_timing_gen u0 (.Clk(clk), .Reset(rst[0]), .pix_tick(pt[0]), .hs(hs[0]), .vs(vs[0]),
    .blank(bl[0]), .sync(sy[0]), .DrawX(dx[0]), .DrawY(dy[0]), .line_start(ls[0]),
    .frame_start(fs[0]), .win_active(wa[0]), .WinX(wx[0]), .WinY(wy[0]));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .CLK_DIV(1)) u1 (.Clk(clk), .Reset(rst[1]),
    .pix_tick(pt[1]), .hs(hs[1]), .vs(vs[1]), .blank(bl[1]), .sync(sy[1]), .DrawX(dx[1]),
    .DrawY(dy[1]), .line_start(ls[1]), .frame_start(fs[1]), .win_active(wa[1]),
    .WinX(wx[1]), .WinY(wy[1]));

  vga_timing_gen #(.H_ACTIVE(40), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(20), .V_FP(1),
    .V_SYNC(2), .V_BP(2), .VS_POL(1'b1), .CLK_DIV(3), .WIN_X0(8), .WIN_Y0(3),
    .WIN_SHIFT(0)) u2 (.Clk(clk), .Reset(rst[2]), .pix_tick(pt[2]), .hs(hs[2]), .vs(vs[2]),
    .blank(bl[2]), .sync(sy[2]), .DrawX(dx[2]), .DrawY(dy[2]), .line_start(ls[2]),
    .frame_start(fs[2]), .win_active(wa[2]), .WinX(wx[2]), .WinY(wy[2]));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .CLK_DIV(1), .WIN_X0(0),
    .WIN_Y0(0), .WIN_SHIFT(1)) u3 (.Clk(clk), .Reset(rst[3]), .pix_tick(pt[3]), .hs(hs[3]),
    .vs(vs[3]), .blank(bl[3]), .sync(sy[3]), .DrawX(dx[3]), .DrawY(dy[3]),
    .line_start(ls[3]), .frame_start(fs[3]), .win_active(wa[3]), .WinX(wx[3]), .WinY(wy[3]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Expected outputs k cycles after the reset edge (k=0 is the cycle right after it).
  function automatic logic [63:0] model(input cfg_t c, input int k);
    int ht, vt, n, p, x, y;
    logic pix, adv, h, v, b, w, l, f;
    logic [8:0] wxv;
    logic [7:0] wyv;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    pix = (k > 0) && (k % c.div == 0);
    n   = (k > 0) ? (k - 1) / c.div : 0;
    p   = n % (ht * vt);
    x   = p % ht;
    y   = p / ht;
    adv = (k > 1) && ((k - 1) % c.div == 0);
    h   = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hs) ? (c.hp != 0) : (c.hp == 0);
    v   = (y >= c.va + c.vf && y < c.va + c.vf + c.vs) ? (c.vp != 0) : (c.vp == 0);
    b   = (x < c.ha) && (y < c.va);
    w   = b && x >= c.wx && x < c.wx + (256 << c.ws) && y >= c.wy && y < c.wy + (240 << c.ws);
    wxv = w ? 9'((x - c.wx) >> c.ws) : 9'd0;
    wyv = w ? 8'((y - c.wy) >> c.ws) : 8'd0;
    l   = adv && (x == 0);
    f   = l && (y == 0);
    return {17'd0, pix, h, v, b, 1'b0, l, f, w, 11'(x), 11'(y), wxv, wyv};
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      k[i] <= rst[i] ? 0 : ((k[i] < 0) ? -1 : k[i] + 1);

  int lk0 = -1, lk1 = -1, fk1 = -1, pk2 = -1, bc3 = 0;
  bit bv3 = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (k[i] >= 0)
        chk($sformatf("dut%0d raster k=%0d", i, k[i]),
            {17'd0, pt[i], hs[i], vs[i], bl[i], sy[i], ls[i], fs[i], wa[i], dx[i], dy[i], wx[i], wy[i]},
            model(cfg[i], k[i]));
    // default timing, hand-computed boundaries
    if (k[0] == 0) begin
      lk0 = -1;
      chk("d0 reset state", 64'({pt[0], hs[0], vs[0], bl[0], ls[0], fs[0], dx[0], dy[0]}),
          64'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0}));
      hit[0] = 1'b1;
    end
    if (k[0] == 2) begin chk("d0 first tick", 64'({pt[0], dx[0]}), 64'({1'b1, 11'd0})); hit[7] = 1'b1; end
    if (k[0] == 3) chk("d0 first step", 64'({pt[0], dx[0]}), 64'({1'b0, 11'd1}));
    if (k[0] > 0) begin
      if (dy[0] == 0 && dx[0] == 64)  begin chk("d0 win x64",  64'({wa[0], wx[0]}), 64'({1'b1, 9'd0}));   hit[1] = 1'b1; end
      if (dy[0] == 0 && dx[0] == 575) begin chk("d0 win x575", 64'({wa[0], wx[0]}), 64'({1'b1, 9'd255})); hit[2] = 1'b1; end
      if (dy[0] == 0 && dx[0] == 576) begin chk("d0 win x576", 64'({wa[0], wx[0]}), 64'({1'b0, 9'd0}));   hit[3] = 1'b1; end
      if (dx[0] == 656 || dx[0] == 751) begin chk("d0 hs in pulse", 64'(hs[0]), 64'd0); hit[4] = 1'b1; end
      if (dx[0] == 655 || dx[0] == 752) begin chk("d0 hs outside", 64'(hs[0]), 64'd1); hit[5] = 1'b1; end
      if (dy[0] == 0 && dx[0] == 639) chk("d0 blank x639", 64'(bl[0]), 64'd1);
      if (dy[0] == 0 && dx[0] == 640) begin chk("d0 blank x640", 64'(bl[0]), 64'd0); hit[6] = 1'b1; end
      if (ls[0]) begin
        if (lk0 >= 0) begin chk("d0 line period", 64'(k[0] - lk0), 64'd1600); hit[8] = 1'b1; end
        lk0 = k[0];
      end
    end
    // small config, CLK_DIV=1, HS_POL=1
    if (k[1] == 0) begin lk1 = -1; fk1 = -1; end
    if (k[1] > 0) begin
      if (dx[1] == 10 || dx[1] == 11) begin chk("d1 hs active", 64'(hs[1]), 64'd1); hit[9] = 1'b1; end
      if (dx[1] == 9 || dx[1] == 12) chk("d1 hs idle", 64'(hs[1]), 64'd0);
      if (ls[1]) begin
        if (lk1 >= 0) begin chk("d1 line period", 64'(k[1] - lk1), 64'd14); hit[10] = 1'b1; end
        lk1 = k[1];
      end
      if (fs[1]) begin
        if (fk1 >= 0) begin chk("d1 frame period", 64'(k[1] - fk1), 64'd98); hit[11] = 1'b1; end
        fk1 = k[1];
      end
    end
    // CLK_DIV=3 tick spacing
    if (k[2] == 0) pk2 = -1;
    if (k[2] > 0 && pt[2]) begin
      if (pk2 >= 0) begin chk("d2 tick period", 64'(k[2] - pk2), 64'd3); hit[12] = 1'b1; end
      pk2 = k[2];
    end
    // tall config: bottom of 2x window, vsync rows, active pixel count per frame
    if (k[3] == 0) bv3 = 0;
    if (k[3] > 0) begin
      if (dy[3] == 479 && dx[3] == 0) begin chk("d3 winy 479", 64'({wa[3], wy[3]}), 64'({1'b1, 8'd239})); hit[13] = 1'b1; end
      if (dy[3] == 490 || dy[3] == 491) begin chk("d3 vs pulse", 64'(vs[3]), 64'd0); hit[14] = 1'b1; end
      if (dy[3] == 489 || dy[3] == 492) chk("d3 vs idle", 64'(vs[3]), 64'd1);
      if (fs[3]) begin
        if (bv3) begin chk("d3 active count", 64'(bc3), 64'd1920); hit[15] = 1'b1; end
        bv3 = 1;
        bc3 = 0;
      end
      if (bv3 && bl[3]) bc3++;
    end
  end

  int r0 = 0, r1 = 0, r2 = 0;
  bit d0done = 0;

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 64, 0, 1};
    cfg[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 0, 1, 64, 0, 1};
    cfg[2] = '{40, 2, 3, 3, 20, 1, 2, 2, 0, 1, 3, 8, 3, 0};
    cfg[3] = '{4, 1, 1, 1, 480, 10, 2, 33, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 4; i++) rst[i] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    for (int cyc = 0; cyc < 14000; cyc++) begin
      @(negedge clk);
      // mid-line reset of the default instance, 3 cycles long
      if (!d0done && r0 == 0 && k[0] > 0 && dx[0] == 300 && dy[0] == 1) r0 = 3;
      rst[0] = (r0 > 0);
      if (r0 > 0) begin r0--; if (r0 == 0) d0done = 1; end
      if (cyc < 6000 && r1 == 0 && $urandom_range(0, 299) == 0) r1 = $urandom_range(1, 3);
      rst[1] = (r1 > 0);
      if (r1 > 0) r1--;
      if (cyc < 6000 && r2 == 0 && $urandom_range(0, 499) == 0) r2 = $urandom_range(1, 3);
      rst[2] = (r2 > 0);
      if (r2 > 0) r2--;
    end
    chk("d0 mid-line reset reached", 64'(d0done), 64'd1);
    chk("boundary pins reached", 64'(hit), 64'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
